multicycle_seq_ctrl: RTL and testbench
======================================

// Module: multicycle_seq_ctrl
// PURPOSE
//  Parametrised multicycle datapath controller. Generalises the fixed 4-state start/mode controller.
//  - Sequence: one LOAD cycle, then STEPS RUN cycles.
//  - Drives datapath signals: register enable, source select and ALU op.
//  - Latches the mode at start; signals done on the final step.
//  - Supports back-to-back starts and reports busy.
// PARAMETERS
//  STEPS    4  number of RUN cycles after LOAD; legal range >= 2
//  OP_W     2  width of alu_op
//  CNT_W    $clog2(STEPS)  step counter width; derived, do not override
// PORTS
//  clock    in   1      rising-edge clock
//  reset    in   1      asynchronous, active-low reset
//  start    in   1      request a new operation; sampled only when accepted
//  mode     in   1      operation mode; latched into mode_q when start is accepted
//  e        out  1      datapath register enable
//  src_sel  out  1      0 = external operand, 1 = feedback path
//  alu_op   out  OP_W   ALU operation select
//  busy     out  1      high in LOAD and RUN
//  done     out  1      one-cycle pulse on the final RUN step
//  abort    in   1      only when MCU_ABORT_EN is defined
// BEHAVIOUR
//  States (Moore, encoded in package):
//    IDLE: e=0, src_sel=0, alu_op=0, busy=0, done=0.
//    LOAD: e=1, src_sel=0, alu_op=0, busy=1.
//    RUN:  e=1, src_sel=1, busy=1.
//  Transitions:
//    IDLE -> LOAD when start=1; mode_q <= mode; else stay in IDLE.
//    LOAD -> RUN; step <= 0.
//    RUN: step < STEPS-1 -> step+1.
//    RUN: step == STEPS-1 -> IDLE, or -> LOAD if start=1 that cycle (back-to-back; mode re-latched).
//  RUN outputs:
//    alu_op = OP_PASS (0) for step < STEPS-1.
//    Final step: alu_op = mode_q ? OP_B (2) : OP_A (1); done=1.
//  Timing:
//    Latency: start sampled at edge N -> done high in cycle N+1+STEPS; a run occupies STEPS+1 cycles.
//    start while busy and not final step: ignored, not queued.
//    Outputs depend only on state, step and mode_q, never on live mode/start; no X on any output.
//  Reset (asynchronous, active-low):
//    state=IDLE, step=0, mode_q=0, all outputs 0.
//    Mid-operation assertion abandons the run immediately with no done pulse.
//  Counter: step never exceeds STEPS-1; no wrap beyond terminal count.
// CONFIGURATION
//  MCU_ABORT_EN defined:
//    Adds input abort.
//    abort=1 in LOAD/RUN -> next state IDLE, done suppressed even on the final step.
//    Abort has priority over back-to-back start. Ignored in IDLE.
//  MCU_ABORT_EN undefined: no abort port; behaviour exactly as above.
// STRUCTURE
//  multicycle_pkg holds:
//    - state typedef (IDLE/LOAD/RUN)
//    - OP_PASS/OP_A/OP_B constants
//    - default STEPS
//  Sub-module mcu_step_counter (clear, inc, terminal-count flag at STEPS-1).
//  FSM next-state logic, state register and output decode stay in this module.
// TESTING
//  1. STEPS=4, pulse start with mode=0 -> e=1 for 5 cycles; src_sel 0,1,1,1,1;
//     alu_op 0,0,0,0,1; done only in cycle 5.
//  2. Same with mode=1, mode toggled during run -> final alu_op=2 (latched value); busy=1 for 5 cycles.
//  3. start held high continuously -> LOAD follows each final RUN step; done every 5 cycles;
//     no IDLE cycle in between.
//  4. start pulsed during RUN step 1 -> ignored; exactly one done; IDLE afterwards.
//  5. reset driven low during RUN step 2 (async, between edges) -> outputs 0 immediately;
//     no done; start after release runs normally.
//  6. MCU_ABORT_EN, abort=1 at final step with start=1 -> IDLE next cycle; done=0; no new LOAD.
//     Also repeat tests 1 and 3 with STEPS=2 and STEPS=7.

Source files
------------

// File: rtl/multicycle_pkg.sv
// Shared types and constants for the multicycle sequence controller.
// The state encoding and ALU op codes live here so the datapath and the controller use the same values.
package multicycle_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   localparam int STEPS_DEF = 4;
   localparam int OP_W_DEF  = 2;

   localparam int OP_PASS = 0;
   localparam int OP_A    = 1;
   localparam int OP_B    = 2;

endpackage

// File: rtl/multicycle_seq_ctrl_step_counter.sv
// RUN-phase step counter: clears to 0, advances on inc, saturates at STEPS-1.
// tc flags the terminal (final) step.
module mcu_step_counter #(
   parameter int STEPS = 4,
   parameter int CNT_W = $clog2(STEPS)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             inc,
   output logic [CNT_W-1:0] step,
   output logic             tc
);

   assign tc = (step == CNT_W'(STEPS - 1));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         step <= '0;
      end else if (clear) begin
         step <= '0;
      end else if (inc && !tc) begin
         step <= step + 1'b1;
      end
   end

endmodule

// File: rtl/multicycle_seq_ctrl.sv
// Multicycle datapath controller: one LOAD cycle followed by STEPS RUN cycles.
// Optional abort input is compiled in when MCU_ABORT_EN is defined.
module multicycle_seq_ctrl
   import multicycle_pkg::*;
#(
   parameter int STEPS = STEPS_DEF,
   parameter int OP_W  = OP_W_DEF
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            start,
   input  logic            mode,
`ifdef MCU_ABORT_EN
   input  logic            abort,
`endif
   output logic            e,
   output logic            src_sel,
   output logic [OP_W-1:0] alu_op,
   output logic            busy,
   output logic            done
);

   localparam int CNT_W = $clog2(STEPS);

   state_t           state, state_nxt;
   logic             mode_q;
   logic             load_mode;
   logic             abort_hit;
   logic             cnt_clear;
   logic             cnt_inc;
   logic [CNT_W-1:0] step;
   logic             tc;

`ifdef MCU_ABORT_EN
   // Abort only matters while a run is in flight.
   assign abort_hit = abort && (state != ST_IDLE);
`else
   assign abort_hit = 1'b0;
`endif

   mcu_step_counter #(
      .STEPS (STEPS),
      .CNT_W (CNT_W)
   ) u_cnt (
      .clock (clock),
      .reset (reset),
      .clear (cnt_clear),
      .inc   (cnt_inc),
      .step  (step),
      .tc    (tc)
   );

   // Counter is 0 on entry to RUN and is returned to 0 whenever RUN ends.
   assign cnt_inc   = (state == ST_RUN);
   assign cnt_clear = (state != ST_RUN) || tc || abort_hit;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state  <= ST_IDLE;
         mode_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (load_mode) begin
            mode_q <= mode;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      load_mode = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_LOAD;
               load_mode = 1'b1;
            end
         end
         ST_LOAD: begin
            state_nxt = abort_hit ? ST_IDLE : ST_RUN;
         end
         ST_RUN: begin
            if (abort_hit) begin
               state_nxt = ST_IDLE;
            end else if (tc) begin
               if (start) begin
                  state_nxt = ST_LOAD;
                  load_mode = 1'b1;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      e       = 1'b0;
      src_sel = 1'b0;
      alu_op  = OP_W'(OP_PASS);
      busy    = 1'b0;
      done    = 1'b0;
      unique case (state)
         ST_LOAD: begin
            e    = 1'b1;
            busy = 1'b1;
         end
         ST_RUN: begin
            e       = 1'b1;
            src_sel = 1'b1;
            busy    = 1'b1;
            if (tc) begin
               alu_op = mode_q ? OP_W'(OP_B) : OP_W'(OP_A);
               done   = !abort_hit;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_multicycle_seq_ctrl.sv
// Directed bench for multicycle_seq_ctrl with STEPS = 4, 2 and 7 instances sharing stimulus.
// Abort scenario is included when MCU_ABORT_EN is defined.
module tb_multicycle_seq_ctrl;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       mode  = 1'b0;
`ifdef MCU_ABORT_EN
   logic       abort = 1'b0;
`endif

   logic [2:0] e_v, src_v, busy_v, done_v;
   logic [1:0] alu_v [3];

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   multicycle_seq_ctrl #(.STEPS(4), .OP_W(2)) u4 (
      .clock (clock), .reset (reset), .start (start), .mode (mode),
`ifdef MCU_ABORT_EN
      .abort (abort),
`endif
      .e (e_v[0]), .src_sel (src_v[0]), .alu_op (alu_v[0]),
      .busy (busy_v[0]), .done (done_v[0])
   );

   multicycle_seq_ctrl #(.STEPS(2), .OP_W(2)) u2 (
      .clock (clock), .reset (reset), .start (start), .mode (mode),
`ifdef MCU_ABORT_EN
      .abort (1'b0),
`endif
      .e (e_v[1]), .src_sel (src_v[1]), .alu_op (alu_v[1]),
      .busy (busy_v[1]), .done (done_v[1])
   );

   multicycle_seq_ctrl #(.STEPS(7), .OP_W(2)) u7 (
      .clock (clock), .reset (reset), .start (start), .mode (mode),
`ifdef MCU_ABORT_EN
      .abort (1'b0),
`endif
      .e (e_v[2]), .src_sel (src_v[2]), .alu_op (alu_v[2]),
      .busy (busy_v[2]), .done (done_v[2])
   );

   // {e, busy, src_sel, alu_op[1:0], done}
   function automatic logic [5:0] outs(input int idx);
      return {e_v[idx], busy_v[idx], src_v[idx], alu_v[idx], done_v[idx]};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drain();
      start = 1'b0;
      repeat (10) tick();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      start = 1'b1;
      #3;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (outs(i) !== 6'b0) begin
            failures++;
            $display("FAIL reset_outs[%0d] got=%b exp=%b", i, outs(i), 6'b0);
         end
      end
      tick();
      start = 1'b0;
      reset = 1'b1;
      tick();
      checks++;
      if (outs(0) !== 6'b0) begin
         failures++;
         $display("FAIL idle_after_reset got=%b exp=%b", outs(0), 6'b0);
      end
   endtask

   // Single run on instance idx with n steps; optionally toggles mode every cycle.
   task automatic test_single(input int idx, input int n, input logic m, input bit toggle);
      logic [5:0] exp;
      logic [1:0] fin;
      fin   = m ? 2'd2 : 2'd1;
      mode  = m;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c <= n; c++) begin
         if (toggle) mode = ~mode;
         exp = {1'b1, 1'b1, (c != 0), (c == n) ? fin : 2'd0, (c == n)};
         checks++;
         if (outs(idx) !== exp) begin
            failures++;
            $display("FAIL single[s%0d m%0b] cyc=%0d got=%b exp=%b", n, m, c, outs(idx), exp);
         end
         tick();
      end
      checks++;
      if (outs(idx) !== 6'b0) begin
         failures++;
         $display("FAIL single_idle[s%0d] got=%b exp=%b", n, outs(idx), 6'b0);
      end
   endtask

   // start held high: LOAD immediately follows each final step.
   task automatic test_back_to_back(input int idx, input int n);
      logic [5:0] exp;
      int ph;
      mode  = 1'b0;
      start = 1'b1;
      tick();
      for (int c = 0; c < 3 * (n + 1); c++) begin
         if (c == 3 * (n + 1) - 1) start = 1'b0;
         ph  = c % (n + 1);
         exp = {1'b1, 1'b1, (ph != 0), (ph == n) ? 2'd1 : 2'd0, (ph == n)};
         checks++;
         if (outs(idx) !== exp) begin
            failures++;
            $display("FAIL b2b[s%0d] cyc=%0d got=%b exp=%b", n, c, outs(idx), exp);
         end
         tick();
      end
      checks++;
      if (outs(idx) !== 6'b0) begin
         failures++;
         $display("FAIL b2b_idle[s%0d] got=%b exp=%b", n, outs(idx), 6'b0);
      end
   endtask

   task automatic test_ignore_start();
      int dn = 0;
      int bz = 0;
      mode  = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 10; c++) begin
         start = (c == 2);
         if (done_v[0] === 1'b1) dn++;
         if (c >= 6 && busy_v[0] !== 1'b0) bz++;
         tick();
      end
      checks++;
      if (dn != 1) begin
         failures++;
         $display("FAIL ignore_done_count got=%0d exp=%0d", dn, 1);
      end
      checks++;
      if (bz != 0) begin
         failures++;
         $display("FAIL ignore_idle_after busy_cycles got=%0d exp=%0d", bz, 0);
      end
   endtask

   task automatic test_async_reset();
      int dn = 0;
      mode  = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      checks++;
      if (outs(0) !== {1'b1, 1'b1, 1'b1, 2'd0, 1'b0}) begin
         failures++;
         $display("FAIL pre_reset_step2 got=%b exp=%b", outs(0), 6'b111000);
      end
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if (outs(0) !== 6'b0) begin
         failures++;
         $display("FAIL async_reset_outs got=%b exp=%b", outs(0), 6'b0);
      end
      for (int c = 0; c < 4; c++) begin
         if (done_v[0] === 1'b1) dn++;
         tick();
      end
      reset = 1'b1;
      for (int c = 0; c < 6; c++) begin
         if (done_v[0] === 1'b1) dn++;
         tick();
      end
      checks++;
      if (dn != 0) begin
         failures++;
         $display("FAIL reset_no_done got=%0d exp=%0d", dn, 0);
      end
      test_single(0, 4, 1'b0, 1'b0);
   endtask

`ifdef MCU_ABORT_EN
   task automatic test_abort();
      mode  = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      start = 1'b1;
      abort = 1'b1;
      #1;
      checks++;
      if (done_v[0] !== 1'b0) begin
         failures++;
         $display("FAIL abort_done got=%b exp=%b", done_v[0], 1'b0);
      end
      tick();
      start = 1'b0;
      abort = 1'b0;
      checks++;
      if (outs(0) !== 6'b0) begin
         failures++;
         $display("FAIL abort_idle got=%b exp=%b", outs(0), 6'b0);
      end
      tick();
      checks++;
      if (busy_v[0] !== 1'b0) begin
         failures++;
         $display("FAIL abort_no_load got=%b exp=%b", busy_v[0], 1'b0);
      end
      abort = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      checks++;
      if (busy_v[0] !== 1'b1) begin
         failures++;
         $display("FAIL abort_ignored_idle got=%b exp=%b", busy_v[0], 1'b1);
      end
      drain();
   endtask
`endif

   initial begin
      test_reset();
      drain();
      test_single(0, 4, 1'b0, 1'b0);
      drain();
      test_single(0, 4, 1'b1, 1'b1);
      drain();
      test_back_to_back(0, 4);
      drain();
      test_ignore_start();
      drain();
      test_async_reset();
      drain();
      test_single(1, 2, 1'b0, 1'b0);
      drain();
      test_back_to_back(1, 2);
      drain();
      test_single(2, 7, 1'b1, 1'b1);
      drain();
      test_back_to_back(2, 7);
      drain();
`ifdef MCU_ABORT_EN
      test_abort();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
